// File: rtl/glitch_free_clock_divider.sv
// glitch_free_clock_divider: registered clk/(2*(cur_div+1)) divider; ratio changes and stop only at the clk_out falling edge.
// Define GFCD_REQ_OVERWRITE_EN to let div_req while busy overwrite the pending ratio (last-wins).
module glitch_free_clock_divider #(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic             running,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out
);
  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, pend_q, pend_d;
  logic             clk_out_q, clk_out_d, busy_q, busy_d, ack_q, ack_d, running_q, running_d;
  logic             active, hit, fall, apply;
  always_comb begin
    active    = state_q != STOP;
    hit       = active && cnt_q == cur_div_q;
    fall      = hit && clk_out_q;
    apply     = busy_q && (!active || fall);
    cur_div_d = apply ? pend_q : cur_div_q;
    ack_d     = apply;
`ifdef GFCD_REQ_OVERWRITE_EN
    pend_d    = div_req ? div_val : pend_q;
    busy_d    = div_req || (busy_q && !apply);
`else
    pend_d    = (div_req && !busy_q) ? div_val : pend_q;
    busy_d    = busy_q ? !apply : div_req;
`endif
    clk_out_d = active ? clk_out_q ^ hit : en;
    cnt_d     = (active && !hit) ? cnt_q + 1'b1 : '0;
    // a falling edge with en low ends the drain; en high at any time resumes RUN
    state_d   = !active ? (en ? RUN : STOP) : (fall && !en) ? STOP : en ? RUN : DRAIN;
    running_d = state_d != STOP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= STOP;
      cnt_q     <= '0;
      cur_div_q <= RESET_DIV;
      pend_q    <= '0;
      clk_out_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      running_q <= running_d;
    end
  end
  assign div_ack = ack_q;
  assign busy    = busy_q;
  assign running = running_q;
  assign cur_div = cur_div_q;
  assign clk_out = clk_out_q;
endmodule

// File: tb/tb_glitch_free_clock_divider.sv
// tb_glitch_free_clock_divider: randomized scoreboard bench against a phase-length reference model.
module tb_glitch_free_clock_divider;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b0, en = 1'b0, div_req = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_ack, busy, running, clk_out;
  logic [W-1:0] cur_div;

  glitch_free_clock_divider #(.DIV_W(W), .RESET_DIV('0)) dut (
    .clk(clk), .rst(rst), .en(en), .div_req(div_req), .div_val(div_val),
    .div_ack(div_ack), .busy(busy), .running(running), .cur_div(cur_div), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         clk_out;
    logic         running;
    logic         busy;
    logic         ack;
    logic [W-1:0] cur;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  int           mode;
  bit           lvl, m_busy, m_ack;
  int           left;
  logic [W-1:0] m_cur, m_pend;

  function automatic obs_t dut_obs();
    return {clk_out, running, busy, div_ack, cur_div};
  endfunction

  function automatic obs_t model_obs();
    return {lvl, mode != 0, m_busy, m_ack, m_cur};
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got clk_out=%0b running=%0b busy=%0b ack=%0b cur_div=%0d, expected clk_out=%0b running=%0b busy=%0b ack=%0b cur_div=%0d",
               name, $time, got.clk_out, got.running, got.busy, got.ack, got.cur,
               exp.clk_out, exp.running, exp.busy, exp.ack, exp.cur);
    end
  endtask

  task automatic model_reset();
    mode = 0; lvl = 0; left = 0; m_cur = '0; m_pend = '0; m_busy = 0; m_ack = 0;
  endtask

  // mode: 0 stopped, 1 running, 2 draining; left = cycles remaining in the current phase
  task automatic model_step(bit e, bit r, logic [W-1:0] v);
    bit           endp, bnd, app;
    logic [W-1:0] nc;
    endp  = mode != 0 && left == 1;
    bnd   = endp && lvl;
    app   = m_busy && (mode == 0 || bnd);
    nc    = app ? m_pend : m_cur;
    m_ack = app;
`ifdef GFCD_REQ_OVERWRITE_EN
    if (r) m_pend = v;
    m_busy = r || (m_busy && !app);
`else
    if (m_busy) m_busy = !app;
    else if (r) begin m_pend = v; m_busy = 1; end
`endif
    if (mode == 0) begin
      if (e) begin mode = 1; lvl = 1; left = int'(nc) + 1; end
    end else begin
      if (endp) begin lvl = !lvl; left = int'(nc) + 1; end
      else left--;
      mode = (bnd && !e) ? 0 : (e ? 1 : 2);
    end
    m_cur = nc;
  endtask

  task automatic cycle(bit e, bit r, logic [W-1:0] v);
    en = e; div_req = r; div_val = v;
    if (!rst) model_reset();
    else model_step(e, r, v);
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst", dut_obs(), model_obs());
    repeat (2) cycle(0, 0, '0);
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("cycle", dut_obs(), exp_q.pop_front());
    end
  end

  initial begin
    bit e;
    int guard;
    model_reset();
    repeat (2) cycle(0, 0, '0);
    rst = 1'b1;
    repeat (6) cycle(1, 0, '0);
    cycle(1, 1, 8'd1);
    repeat (10) cycle(1, 0, '0);
    cycle(1, 1, 8'd3);
    repeat (24) cycle(1, 0, '0);
    guard = 0;
    while (!(lvl && left == int'(m_cur)) && guard < 50) begin cycle(1, 0, '0); guard++; end
    repeat (14) cycle(0, 0, '0);
    cycle(0, 1, 8'd2);
    repeat (2) cycle(0, 0, '0);
    repeat (14) cycle(1, 0, '0);
    cycle(1, 1, 8'd5);
    cycle(1, 1, 8'd7);
    repeat (40) cycle(1, 0, '0);
    guard = 0;
    while (!lvl && guard < 50) begin cycle(1, 0, '0); guard++; end
    async_reset();
    repeat (6) cycle(1, 0, '0);
    e = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) e = !e;
      if ($urandom_range(0, 799) == 0) async_reset();
      else cycle(e, $urandom_range(0, 5) == 0, 8'($urandom_range(0, 4)));
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
